// File: rtl/sysid_check.sv
// Reads the system-ID and timestamp registers over Avalon-MM and compares them
// against the values this image was built with; reports pass, mismatch or read timeout.
module sysid_check #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1362923971,
    parameter int unsigned TIMEOUT            = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, DONE, FAIL} state_t;

    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    logic [16:0] wait_next;
    logic        last_wait;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            armed_q    <= AUTO_START;
            wait_cnt_q <= '0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            wait_cnt_q <= wait_cnt_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    // The stalled edge that would bring the count up to TIMEOUT abandons the read.
    assign wait_next = {1'b0, wait_cnt_q} + 17'd1;
    assign last_wait = (wait_next == TIMEOUT_W);

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        wait_cnt_d = wait_cnt_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        case (state_q)
            IDLE: begin
                if (start || armed_q) begin
                    state_d    = RD_ID;
                    armed_d    = 1'b0;
                    wait_cnt_d = '0;
                end
            end
            RD_ID: begin
                if (!waitrequest) begin
                    id_value_d = readdata;
                    id_ok_d    = (readdata == EXPECTED_ID);
                    state_d    = RD_TS;
                    wait_cnt_d = '0;
                end else if (last_wait) begin
                    state_d = FAIL;
                end else begin
                    wait_cnt_d = wait_next[15:0];
                end
            end
            RD_TS: begin
                if (!waitrequest) begin
                    ts_value_d = readdata;
                    ts_ok_d    = (readdata == EXPECTED_TIMESTAMP);
                    state_d    = DONE;
                end else if (last_wait) begin
                    state_d = FAIL;
                end else begin
                    wait_cnt_d = wait_next[15:0];
                end
            end
            DONE, FAIL: begin
                // Captured values survive a rerun until the new reads overwrite them.
                if (start) begin
                    state_d    = RD_ID;
                    id_ok_d    = 1'b0;
                    ts_ok_d    = 1'b0;
                    wait_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == RD_ID) || (state_q == RD_TS);
        read     = busy;
        address  = (state_q == RD_TS);
        done     = (state_q == DONE) || (state_q == FAIL);
        timeout  = (state_q == FAIL);
        pass     = (state_q == DONE) && id_ok_q && ts_ok_q;
        id_ok    = id_ok_q;
        ts_ok    = ts_ok_q;
        id_value = id_value_q;
        ts_value = ts_value_q;
    end

endmodule

// File: tb/tb_sysid_check.sv
// Directed bench for sysid_check: default instance, short-timeout instance and
// manual-start instance, each driven by a simple address-decoded slave model.
module tb_sysid_check;

    localparam logic [31:0] TS = 32'd1362923971;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance A: all defaults
    logic rst_a, start_a, wait_a, addr_a, read_a, busy_a, done_a, pass_a, idok_a, tsok_a, to_a;
    logic [31:0] id_a, ts_a, rdata_a, idv_a, tsv_a;
    assign rdata_a = addr_a ? ts_a : id_a;

    // Instance B: TIMEOUT=4
    logic rst_b, start_b, wait_b, addr_b, read_b, busy_b, done_b, pass_b, idok_b, tsok_b, to_b;
    logic [31:0] rdata_b, idv_b, tsv_b;
    assign rdata_b = addr_b ? TS : 32'd0;

    // Instance C: AUTO_START=0
    logic rst_c, start_c, wait_c, addr_c, read_c, busy_c, done_c, pass_c, idok_c, tsok_c, to_c;
    logic [31:0] id_c, rdata_c, idv_c, tsv_c;
    assign rdata_c = addr_c ? TS : id_c;

    sysid_check dut_a (
        .clock(clk), .reset(rst_a), .start(start_a), .address(addr_a), .read(read_a),
        .readdata(rdata_a), .waitrequest(wait_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .id_ok(idok_a), .ts_ok(tsok_a), .timeout(to_a), .id_value(idv_a), .ts_value(tsv_a)
    );

    sysid_check #(.TIMEOUT(4)) dut_b (
        .clock(clk), .reset(rst_b), .start(start_b), .address(addr_b), .read(read_b),
        .readdata(rdata_b), .waitrequest(wait_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .id_ok(idok_b), .ts_ok(tsok_b), .timeout(to_b), .id_value(idv_b), .ts_value(tsv_b)
    );

    sysid_check #(.AUTO_START(0)) dut_c (
        .clock(clk), .reset(rst_c), .start(start_c), .address(addr_c), .read(read_c),
        .readdata(rdata_c), .waitrequest(wait_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .id_ok(idok_c), .ts_ok(tsok_c), .timeout(to_c), .id_value(idv_c), .ts_value(tsv_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (read_a !== 1'b0) begin failures++; $display("FAIL reset_read got=%0d exp=0", read_a); end
        checks++; if (addr_a !== 1'b0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", addr_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got=%0d exp=0", done_a); end
        checks++; if (pass_a !== 1'b0) begin failures++; $display("FAIL reset_pass got=%0d exp=0", pass_a); end
        checks++; if (to_a !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%0d exp=0", to_a); end
        checks++; if (idv_a !== 32'd0) begin failures++; $display("FAIL reset_idv got=%h exp=0", idv_a); end
        checks++; if (tsv_a !== 32'd0) begin failures++; $display("FAIL reset_tsv got=%h exp=0", tsv_a); end
        $display("test_reset: outputs sampled under reset");
    endtask

    task automatic test_auto_start();
        tick();
        rst_a = 1'b0;
        tick();
        checks++; if (read_a !== 1'b1) begin failures++; $display("FAIL auto_read0 got=%0d exp=1", read_a); end
        checks++; if (addr_a !== 1'b0) begin failures++; $display("FAIL auto_addr0 got=%0d exp=0", addr_a); end
        tick();
        checks++; if (read_a !== 1'b1) begin failures++; $display("FAIL auto_read1 got=%0d exp=1", read_a); end
        checks++; if (addr_a !== 1'b1) begin failures++; $display("FAIL auto_addr1 got=%0d exp=1", addr_a); end
        tick();
        checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL auto_done got=%0d exp=1", done_a); end
        checks++; if (pass_a !== 1'b1) begin failures++; $display("FAIL auto_pass got=%0d exp=1", pass_a); end
        checks++; if (read_a !== 1'b0) begin failures++; $display("FAIL auto_read_end got=%0d exp=0", read_a); end
        checks++; if (idv_a !== 32'd0) begin failures++; $display("FAIL auto_idv got=%h exp=0", idv_a); end
        checks++; if (tsv_a !== TS) begin failures++; $display("FAIL auto_tsv got=%h exp=%h", tsv_a, TS); end
        $display("test_auto_start: check ran after reset release");
    endtask

    task automatic test_ts_mismatch();
        ts_a = 32'h12345678;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL mm_done_clr got=%0d exp=0", done_a); end
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL mm_busy got=%0d exp=1", busy_a); end
        tick();
        tick();
        checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL mm_done got=%0d exp=1", done_a); end
        checks++; if (idok_a !== 1'b1) begin failures++; $display("FAIL mm_idok got=%0d exp=1", idok_a); end
        checks++; if (tsok_a !== 1'b0) begin failures++; $display("FAIL mm_tsok got=%0d exp=0", tsok_a); end
        checks++; if (pass_a !== 1'b0) begin failures++; $display("FAIL mm_pass got=%0d exp=0", pass_a); end
        checks++; if (tsv_a !== 32'h12345678) begin failures++; $display("FAIL mm_tsv got=%h exp=12345678", tsv_a); end
        ts_a = TS;
        $display("test_ts_mismatch: timestamp mismatch reported");
    endtask

    task automatic test_wait_states();
        start_a = 1'b1;
        wait_a = 1'b0;
        tick();
        start_a = 1'b0;
        // Edges 1-5 stall the ID read, edge 6 accepts; 7-11 stall the TS read, 12 accepts.
        for (int k = 1; k <= 12; k++) begin
            wait_a = ((k <= 5) || (k >= 7 && k <= 11));
            tick();
            checks++; if (addr_a !== ((k >= 6 && k < 12) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL ws_addr edge=%0d got=%0d", k, addr_a); end
            checks++; if (done_a !== ((k == 12) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL ws_done edge=%0d got=%0d", k, done_a); end
        end
        wait_a = 1'b0;
        checks++; if (pass_a !== 1'b1) begin failures++; $display("FAIL ws_pass got=%0d exp=1", pass_a); end
        $display("test_wait_states: 5-cycle stalls on both reads");
    endtask

    task automatic test_back_to_back();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL b2b_done got=%0d exp=1", done_a); end
        tick();
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL b2b_noqueue got=%0d exp=0", busy_a); end
        checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL b2b_held got=%0d exp=1", done_a); end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL b2b_rerun got=%0d exp=1", busy_a); end
        checks++; if (idok_a !== 1'b0) begin failures++; $display("FAIL b2b_idok_clr got=%0d exp=0", idok_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL b2b_done_clr got=%0d exp=0", done_a); end
        tick();
        tick();
        checks++; if (pass_a !== 1'b1) begin failures++; $display("FAIL b2b_pass got=%0d exp=1", pass_a); end
        $display("test_back_to_back: start during read ignored, start in DONE reruns");
    endtask

    task automatic test_timeout();
        tick();
        rst_b = 1'b0;
        wait_b = 1'b0;
        tick();
        tick();
        wait_b = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (busy_b !== 1'b1) begin failures++; $display("FAIL to_busy3 got=%0d exp=1", busy_b); end
        tick();
        checks++; if (read_b !== 1'b0) begin failures++; $display("FAIL to_read got=%0d exp=0", read_b); end
        checks++; if (to_b !== 1'b1) begin failures++; $display("FAIL to_flag got=%0d exp=1", to_b); end
        checks++; if (idok_b !== 1'b1) begin failures++; $display("FAIL to_idok got=%0d exp=1", idok_b); end
        checks++; if (tsok_b !== 1'b0) begin failures++; $display("FAIL to_tsok got=%0d exp=0", tsok_b); end
        checks++; if (pass_b !== 1'b0) begin failures++; $display("FAIL to_pass got=%0d exp=0", pass_b); end
        checks++; if (done_b !== 1'b1) begin failures++; $display("FAIL to_done got=%0d exp=1", done_b); end
        wait_b = 1'b0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        checks++; if (to_b !== 1'b0) begin failures++; $display("FAIL to_clr got=%0d exp=0", to_b); end
        tick();
        tick();
        checks++; if (pass_b !== 1'b1) begin failures++; $display("FAIL to_rerun_pass got=%0d exp=1", pass_b); end
        $display("test_timeout: stuck TS read hits TIMEOUT=4");
    endtask

    task automatic test_reset_abort();
        id_c = 32'hA5A50001;
        tick();
        rst_c = 1'b0;
        tick();
        tick();
        checks++; if (read_c !== 1'b0) begin failures++; $display("FAIL ab_noauto got=%0d exp=0", read_c); end
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        tick();
        tick();
        checks++; if (idv_c !== 32'hA5A50001) begin failures++; $display("FAIL ab_idv1 got=%h exp=a5a50001", idv_c); end
        checks++; if (pass_c !== 1'b0) begin failures++; $display("FAIL ab_pass1 got=%0d exp=0", pass_c); end
        wait_c = 1'b1;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        checks++; if (read_c !== 1'b1) begin failures++; $display("FAIL ab_rd got=%0d exp=1", read_c); end
        #2 rst_c = 1'b1;
        #1;
        checks++; if (read_c !== 1'b0) begin failures++; $display("FAIL ab_read got=%0d exp=0", read_c); end
        checks++; if (busy_c !== 1'b0) begin failures++; $display("FAIL ab_busy got=%0d exp=0", busy_c); end
        checks++; if (done_c !== 1'b0) begin failures++; $display("FAIL ab_done got=%0d exp=0", done_c); end
        checks++; if (idv_c !== 32'd0) begin failures++; $display("FAIL ab_idv got=%h exp=0", idv_c); end
        checks++; if (tsv_c !== 32'd0) begin failures++; $display("FAIL ab_tsv got=%h exp=0", tsv_c); end
        tick();
        rst_c = 1'b0;
        wait_c = 1'b0;
        id_c = 32'd0;
        tick();
        tick();
        checks++; if (read_c !== 1'b0) begin failures++; $display("FAIL ab_idle got=%0d exp=0", read_c); end
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        tick();
        tick();
        checks++; if (pass_c !== 1'b1) begin failures++; $display("FAIL ab_pass2 got=%0d exp=1", pass_c); end
        $display("test_reset_abort: reset mid-read clears everything, manual start works");
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        wait_a = 1'b0; wait_b = 1'b0; wait_c = 1'b0;
        id_a = 32'd0; ts_a = TS; id_c = 32'd0;
        test_reset();
        test_auto_start();
        test_ts_mismatch();
        test_wait_states();
        test_back_to_back();
        test_timeout();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
